vga_frame_buffer_dbl: RTL and testbench
=======================================

# vga_frame_buffer_dbl

Parametrised, double-buffered (ping-pong) pixel frame store between the image-masking pipeline and the VGA scan-out. The pipeline writes a complete frame into the back bank while the display reads the front bank. Banks swap only on a display frame boundary, so the display never shows a torn frame. After each swap, the new back bank can optionally be auto-cleared to a blank colour.

## Interface
- PIXEL_W, 12, pixel data width (RGB444)
- ROW_W, 8, row index width
- COL_W, 9, column index width
- ROWS, 240, visible rows per frame
- COLS, 320, visible columns per frame
- BLANK, 0, pixel value returned for out-of-range reads and written by auto-clear
- CLEAR_EN, 1, 1 = clear back bank after every swap

Ports:
- clk  in  1  system clock; one clock domain
- rst  in  1  synchronous reset, active-high
- wr_en  in  1  write strobe; accepted only when wr_ready=1
- wr_row  in  ROW_W  write row
- wr_col  in  COL_W  write column
- wr_pixel  in  PIXEL_W  write data
- wr_ready  out  1  back bank accepting writes
- frame_done  in  1  one-cycle pulse: writer finished a frame
- rd_row  in  ROW_W  read row
- rd_col  in  COL_W  read column
- frame_start  in  1  one-cycle pulse from VGA timing at start of vertical blank
- rd_pixel  out  PIXEL_W  registered read data
- front_sel  out  1  bank currently displayed (0/1)
- swap_pending  out  1  frame_done seen, waiting for frame_start
- clear_busy  out  1  auto-clear in progress

## Operation
- Storage: 2 × ROWS·COLS words of PIXEL_W. Address = row·COLS + col.
- Write path: back bank = !front_sel. A write is committed when wr_en && wr_ready && row<ROWS && col<COLS. Out-of-range writes are silently dropped.
- Read path: always reads the front bank. Out-of-range coordinates return BLANK.
- FSM states: FILL, PENDING, CLEAR.
  - FILL: wr_ready=1. frame_done → PENDING.
  - PENDING: wr_ready=0; writes are dropped. frame_start → toggle front_sel, then go to CLEAR if CLEAR_EN, else FILL.
  - CLEAR: wr_ready=0. An address counter runs 0..ROWS·COLS−1 and writes BLANK to the new back bank, one word per cycle. After the last address → FILL. frame_start and frame_done are ignored in this state.
- If frame_done and frame_start arrive in the same cycle while in FILL: the swap happens in that cycle. The write presented in that cycle is still committed to the old back bank. No PENDING cycle occurs.
- frame_start while in FILL without frame_done: no swap; the display repeats the current front frame.
- Second frame_done while in PENDING: ignored.
- Reset: front_sel=0, state FILL, clear counter=0. Memory contents are not reset.

## Timing
- Reset values: rd_pixel=BLANK, front_sel=0, wr_ready=1, swap_pending=0, clear_busy=0.
- Read latency is 1 cycle. rd_pixel in cycle n+1 reflects rd_row/rd_col and front_sel as sampled at the clock edge ending cycle n.
- The swap takes effect on the edge that samples frame_start. Reads sampled on the following edge use the new front bank.
- A write committed at edge n is readable after a swap. Same-bank read-during-write cannot occur, because reads and writes always target opposite banks.
- Clear duration is exactly ROWS·COLS cycles. clear_busy is high throughout; wr_ready rises on the cycle after the last BLANK write.
- wr_ready, swap_pending and clear_busy are registered, decoded from the FSM state.
- Reset asserted mid-CLEAR or mid-PENDING: return to FILL on the next edge, front_sel=0, and the clear is abandoned.

## Structure
- Shared package vga_pkg holds:
  - the state enum (FILL/PENDING/CLEAR)
  - the default ROWS/COLS/PIXEL_W constants
  - the address-width function clog2(ROWS·COLS)
- One sub-module, vga_bank_ram: a single-bank, simple dual-port RAM with one write port, one registered read port, and a depth parameter. It is instantiated twice, with bank-select muxing in the top level. This lets synthesis infer block RAM.

## Test plan
- Reset, then write 0xAAA to (0,0) in FILL with no swap; read (0,0) → rd_pixel stays the old front contents (not 0xAAA) and front_sel=0.
- Write 0xBBB to (5,3), pulse frame_done, then frame_start two cycles later → swap_pending high for 2 cycles, front_sel=1; read (5,3) one cycle later → 0xBBB.
- CLEAR_EN=1, ROWS=4, COLS=4: after the swap, clear_busy is high for exactly 16 cycles; wr_en is ignored throughout; then after a second swap, every address of that bank reads BLANK.
- Write to (ROWS,0) and to (0,COLS), and read (ROWS,0) → writes are dropped, existing contents unchanged, read returns BLANK.
- frame_done and frame_start in the same cycle, with a write of 0xCCC to (2,7) in that cycle → immediate swap, no PENDING; read (2,7) → 0xCCC.
- Assert rst during CLEAR and during PENDING → next cycle: FILL, wr_ready=1, front_sel=0, rd_pixel=BLANK.

Source files
------------

// File: rtl/vga_pkg.sv
// vga_pkg: shared state encoding, default geometry and address-width helper for the frame buffer.
package vga_pkg;
  localparam int DEF_PIXEL_W = 12;
  localparam int DEF_ROWS = 240;
  localparam int DEF_COLS = 320;
  typedef enum logic [1:0] {FILL, PENDING, CLEAR} state_t;
  function automatic int addr_w(int rows, int cols);
    return (rows * cols > 1) ? $clog2(rows * cols) : 1;
  endfunction
endpackage

// File: rtl/vga_bank_ram.sv
// vga_bank_ram: one frame bank, simple dual-port RAM with a registered read port.
module vga_bank_ram #(
  parameter int W = 12,
  parameter int DEPTH = 16,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [W-1:0]  i_wdata,
  input  logic [AW-1:0] i_raddr,
  output logic [W-1:0]  o_rdata
);
  logic [W-1:0] r_mem [DEPTH];
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
    o_rdata <= r_mem[i_raddr];
  end
endmodule

// File: rtl/vga_frame_buffer_dbl.sv
// vga_frame_buffer_dbl: ping-pong frame store; writer fills the back bank, display reads the front,
// banks swap only at a display frame boundary, and the new back bank is optionally blanked.
module vga_frame_buffer_dbl
  import vga_pkg::*;
#(
  parameter int PIXEL_W = DEF_PIXEL_W,
  parameter int ROW_W = 8,
  parameter int COL_W = 9,
  parameter int ROWS = DEF_ROWS,
  parameter int COLS = DEF_COLS,
  parameter logic [PIXEL_W-1:0] BLANK = '0,
  parameter bit CLEAR_EN = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wr_en,
  input  logic [ROW_W-1:0]   wr_row,
  input  logic [COL_W-1:0]   wr_col,
  input  logic [PIXEL_W-1:0] wr_pixel,
  output logic               wr_ready,
  input  logic               frame_done,
  input  logic [ROW_W-1:0]   rd_row,
  input  logic [COL_W-1:0]   rd_col,
  input  logic               frame_start,
  output logic [PIXEL_W-1:0] rd_pixel,
  output logic               front_sel,
  output logic               swap_pending,
  output logic               clear_busy
);
  localparam int DEPTH = ROWS * COLS;
  localparam int AW = addr_w(ROWS, COLS);
  localparam logic [ROW_W:0] ROWS_C = (ROW_W+1)'(ROWS);
  localparam logic [COL_W:0] COLS_C = (COL_W+1)'(COLS);
  state_t r_state, w_next;
  logic r_front_sel, r_rd_oob, r_rd_bank;
  logic [AW-1:0] r_clr_cnt, w_rd_addr, w_wr_addr, w_ram_waddr;
  logic [PIXEL_W-1:0] w_q0, w_q1, w_ram_wdata;
  logic w_rd_in, w_wr_in, w_wr_commit, w_clr_last, w_swap, w_ram_we;
  assign w_rd_in = ({1'b0, rd_row} < ROWS_C) && ({1'b0, rd_col} < COLS_C);
  assign w_wr_in = ({1'b0, wr_row} < ROWS_C) && ({1'b0, wr_col} < COLS_C);
  assign w_rd_addr = AW'(32'(rd_row) * 32'(COLS) + 32'(rd_col));
  assign w_wr_addr = AW'(32'(wr_row) * 32'(COLS) + 32'(wr_col));
  assign w_clr_last = r_clr_cnt == AW'(DEPTH - 1);
  assign w_wr_commit = r_state == FILL && wr_en && w_wr_in;
  // A same-cycle frame_done+frame_start in FILL swaps immediately, skipping PENDING.
  assign w_swap = frame_start && ((r_state == FILL && frame_done) || r_state == PENDING);
  always_comb begin
    w_next = w_swap ? (CLEAR_EN ? CLEAR : FILL)
           : (r_state == FILL && frame_done) ? PENDING
           : (r_state == CLEAR && w_clr_last) ? FILL
           : r_state;
    w_ram_we = !rst && (w_wr_commit || r_state == CLEAR);
    w_ram_waddr = r_state == CLEAR ? r_clr_cnt : w_wr_addr;
    w_ram_wdata = r_state == CLEAR ? BLANK : wr_pixel;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= FILL;
      r_front_sel <= 1'b0;
      r_clr_cnt <= '0;
      r_rd_oob <= 1'b1;
      r_rd_bank <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_swap) r_front_sel <= !r_front_sel;
      r_clr_cnt <= (r_state == CLEAR && !w_clr_last) ? r_clr_cnt + 1'b1 : '0;
      r_rd_oob <= !w_rd_in;
      r_rd_bank <= r_front_sel;
    end
  end
  vga_bank_ram #(.W(PIXEL_W), .DEPTH(DEPTH), .AW(AW)) u_bank0 (
    .clk(clk), .i_we(w_ram_we && r_front_sel), .i_waddr(w_ram_waddr),
    .i_wdata(w_ram_wdata), .i_raddr(w_rd_addr), .o_rdata(w_q0));
  vga_bank_ram #(.W(PIXEL_W), .DEPTH(DEPTH), .AW(AW)) u_bank1 (
    .clk(clk), .i_we(w_ram_we && !r_front_sel), .i_waddr(w_ram_waddr),
    .i_wdata(w_ram_wdata), .i_raddr(w_rd_addr), .o_rdata(w_q1));
  assign rd_pixel = r_rd_oob ? BLANK : (r_rd_bank ? w_q1 : w_q0);
  assign front_sel = r_front_sel;
  assign wr_ready = r_state == FILL;
  assign swap_pending = r_state == PENDING;
  assign clear_busy = r_state == CLEAR;
endmodule

// File: tb/tb_vga_frame_buffer_dbl.sv
// tb_vga_frame_buffer_dbl: directed and random checks of the ping-pong frame store against a frame-level model.
module tb_vga_frame_buffer_dbl;
  localparam int ROWS = 6;
  localparam int COLS = 8;
  localparam int DEPTH = ROWS * COLS;
  localparam logic [11:0] BLANK = 12'h000;
  localparam int M_FILL = 0, M_PEND = 1, M_CLEAR = 2;
  logic clk = 0, rst, wr_en, frame_done, frame_start;
  logic [7:0] wr_row, rd_row;
  logic [8:0] wr_col, rd_col;
  logic [11:0] wr_pixel, rd_pixel;
  logic wr_ready, front_sel, swap_pending, clear_busy;
  logic [11:0] m_mem [2][DEPTH];
  bit m_kn [2][DEPTH];
  int m_front, m_mode, m_clr;
  int n_chk = 0, n_fail = 0;
  always #5 clk = ~clk;
  vga_frame_buffer_dbl #(.PIXEL_W(12), .ROW_W(8), .COL_W(9), .ROWS(ROWS), .COLS(COLS),
    .BLANK(BLANK), .CLEAR_EN(1'b1)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_row(wr_row), .wr_col(wr_col),
    .wr_pixel(wr_pixel), .wr_ready(wr_ready), .frame_done(frame_done),
    .rd_row(rd_row), .rd_col(rd_col), .frame_start(frame_start), .rd_pixel(rd_pixel),
    .front_sel(front_sel), .swap_pending(swap_pending), .clear_busy(clear_busy));
  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic tick();
    bit ri, ek;
    int a;
    logic [11:0] er;
    @(posedge clk);
    ri = rd_row < ROWS && rd_col < COLS;
    a = ri ? int'(rd_row) * COLS + int'(rd_col) : 0;
    if (rst) begin
      er = BLANK;
      ek = 1;
      m_front = 0;
      m_mode = M_FILL;
      m_clr = 0;
    end else begin
      ek = !ri || m_kn[m_front][a];
      er = ri ? m_mem[m_front][a] : BLANK;
      if (m_mode == M_FILL && wr_en && wr_row < ROWS && wr_col < COLS) begin
        m_mem[1-m_front][int'(wr_row) * COLS + int'(wr_col)] = wr_pixel;
        m_kn[1-m_front][int'(wr_row) * COLS + int'(wr_col)] = 1;
      end
      if (m_mode == M_CLEAR) begin
        m_mem[1-m_front][m_clr] = BLANK;
        m_kn[1-m_front][m_clr] = 1;
        m_clr++;
        if (m_clr == DEPTH) begin
          m_clr = 0;
          m_mode = M_FILL;
        end
      end else if (frame_start && (m_mode == M_PEND || frame_done)) begin
        m_front = 1 - m_front;
        m_mode = M_CLEAR;
      end else if (m_mode == M_FILL && frame_done) m_mode = M_PEND;
    end
    #1;
    chk("wr_ready", wr_ready, m_mode == M_FILL);
    chk("swap_pending", swap_pending, m_mode == M_PEND);
    chk("clear_busy", clear_busy, m_mode == M_CLEAR);
    chk("front_sel", front_sel, m_front);
    if (ek) chk("rd_pixel", rd_pixel, er);
  endtask
  task automatic wait_fill(input string tag);
    int n = 0;
    while (!wr_ready && n < 500) begin
      n++;
      tick();
    end
    chk(tag, wr_ready, 1);
  endtask
  initial begin
    int n;
    rst = 1; wr_en = 0; frame_done = 0; frame_start = 0;
    wr_row = 0; wr_col = 0; wr_pixel = 0; rd_row = 0; rd_col = 0;
    m_front = 0; m_mode = M_FILL; m_clr = 0;
    tick(); tick();
    chk("reset_rd_blank", rd_pixel, BLANK);
    rst = 0;
    wr_en = 1; wr_row = 0; wr_col = 0; wr_pixel = 12'hAAA;
    tick();
    wr_en = 0;
    tick();
    chk("t1_no_tear", rd_pixel == 12'hAAA, 0);
    chk("t1_front", front_sel, 0);
    wr_en = 1; wr_row = 5; wr_col = 3; wr_pixel = 12'hBBB;
    tick();
    wr_en = 0; frame_done = 1;
    tick();
    frame_done = 0;
    chk("t2_pend1", swap_pending, 1);
    tick();
    chk("t2_pend2", swap_pending, 1);
    frame_start = 1;
    tick();
    frame_start = 0;
    chk("t2_front", front_sel, 1);
    rd_row = 5; rd_col = 3;
    wr_en = 1; wr_row = 1; wr_col = 1; wr_pixel = 12'h123;
    n = 0;
    while (clear_busy && n < 500) begin
      n++;
      tick();
      if (n == 1) chk("t2_read_bbb", rd_pixel, 12'hBBB);
    end
    chk("t3_clear_len", n, DEPTH);
    wr_en = 0;
    frame_done = 1; frame_start = 1;
    tick();
    frame_done = 0; frame_start = 0;
    chk("t3_front0", front_sel, 0);
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) begin
        rd_row = 8'(r); rd_col = 9'(c);
        tick();
        chk("t3_blank", rd_pixel, BLANK);
      end
    wait_fill("t3_refill");
    wr_en = 1; wr_row = 8'(ROWS); wr_col = 0; wr_pixel = 12'h555;
    tick();
    wr_row = 0; wr_col = 9'(COLS); wr_pixel = 12'h666;
    tick();
    wr_en = 0; rd_row = 8'(ROWS); rd_col = 0;
    tick();
    chk("t4_oob_rd", rd_pixel, BLANK);
    wr_en = 1; wr_row = 2; wr_col = 7; wr_pixel = 12'hCCC;
    frame_done = 1; frame_start = 1;
    tick();
    wr_en = 0; frame_done = 0; frame_start = 0;
    chk("t5_no_pend", swap_pending, 0);
    chk("t5_front", front_sel, 1);
    rd_row = 2; rd_col = 7;
    tick();
    chk("t5_read_ccc", rd_pixel, 12'hCCC);
    tick(); tick();
    rst = 1;
    tick();
    rst = 0;
    chk("t6_clr_rst_ready", wr_ready, 1);
    chk("t6_clr_rst_front", front_sel, 0);
    chk("t6_clr_rst_rd", rd_pixel, BLANK);
    frame_done = 1;
    tick();
    frame_done = 0;
    tick();
    rst = 1;
    tick();
    rst = 0;
    chk("t6_pend_rst_ready", wr_ready, 1);
    chk("t6_pend_rst_pend", swap_pending, 0);
    chk("t6_pend_rst_front", front_sel, 0);
    chk("t6_pend_rst_rd", rd_pixel, BLANK);
    for (int i = 0; i < 1500; i++) begin
      rst = $urandom_range(0, 199) == 0;
      wr_en = $urandom_range(0, 1);
      wr_row = 8'($urandom_range(0, ROWS));
      wr_col = 9'($urandom_range(0, COLS));
      wr_pixel = 12'($urandom);
      frame_done = $urandom_range(0, 19) == 0;
      frame_start = $urandom_range(0, 9) == 0;
      rd_row = 8'($urandom_range(0, ROWS));
      rd_col = 9'($urandom_range(0, COLS));
      tick();
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
